serial_deserializer: RTL and testbench

//   Serial-to-parallel receiver. Collects DATA_WIDTH serial bits into a word and

---
 rtl/serial_deserializer_pkg.sv | 8 +
 rtl/serial_deserializer_if.sv | 24 ++
 rtl/serial_deserializer_register.sv | 32 +++
 rtl/serial_deserializer.sv | 104 ++++++++++
 tb/tb_serial_deserializer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_deserializer_pkg.sv
// Shared constants and helpers for the serial deserializer slice.
package gpu_pkg;
  localparam int DATA_WIDTH_DEF = 16;

  function automatic int CNT_W(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/serial_deserializer_if.sv
// Serial-in / parallel-out bundle; the deserializer is the slave side.
interface serial_deserializer_if import gpu_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  sin;
  logic                  sin_valid;
  logic                  sin_start;
  logic                  sin_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  framing_err;

  modport master (
    output sin, sin_valid, sin_start, out_ready,
    input  sin_ready, out_data, out_valid, busy, framing_err
  );

  modport slave (
    input  sin, sin_valid, sin_start, out_ready,
    output sin_ready, out_data, out_valid, busy, framing_err
  );
endinterface

// File: rtl/serial_deserializer_register.sv
// Generic W-bit register: clear > parallel load > shift left > shift right > hold.
module register import gpu_pkg::*; #(
  parameter int W = DATA_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cl,
  input  logic         ld,
  input  logic [W-1:0] d,
  input  logic         sl,
  input  logic         il,
  input  logic         sr,
  input  logic         ir,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (cl)      q_d = '0;
    else if (ld) q_d = d;
    else if (sl) q_d = {q_q[W-2:0], il};
    else if (sr) q_d = {ir, q_q[W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver with a one-word output buffer, start-bit framing
// and a registered-only sin_ready.
module serial_deserializer import gpu_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  serial_deserializer_if.slave bus
);
  localparam int              CW   = CNT_W(DATA_WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  ferr_q, ferr_d;
  logic [DATA_WIDTH-1:0] sh, word, restart_val, out_word;
  logic                  sin_ready, acc, restart, complete, hs;

  always_comb begin
    // Only the final bit can stall, so ready depends on registers alone.
    sin_ready = !((cnt_q == LAST) && out_valid_q);
    acc       = bus.sin_valid & sin_ready;
    restart   = acc & bus.sin_start & (cnt_q != '0);
    complete  = acc & ~restart & (cnt_q == LAST);
    hs        = out_valid_q & bus.out_ready;
  end

  // Completed word includes the bit arriving this cycle; a restart keeps that bit alone.
  always_comb begin
    if (MSB_FIRST) begin
      word        = {sh[DATA_WIDTH-2:0], bus.sin};
      restart_val = {{(DATA_WIDTH-1){1'b0}}, bus.sin};
    end else begin
      word        = {bus.sin, sh[DATA_WIDTH-1:1]};
      restart_val = {bus.sin, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  register #(.W(DATA_WIDTH)) u_shift (
    .clk (clk),
    .rst_n (rst_n),
    .cl  (clr),
    .ld  (restart),
    .d   (restart_val),
    .sl  (MSB_FIRST ? acc : 1'b0),
    .il  (bus.sin),
    .sr  (MSB_FIRST ? 1'b0 : acc),
    .ir  (bus.sin),
    .q   (sh)
  );

  register #(.W(DATA_WIDTH)) u_obuf (
    .clk (clk),
    .rst_n (rst_n),
    .cl  (clr),
    .ld  (complete),
    .d   (word),
    .sl  (1'b0),
    .il  (1'b0),
    .sr  (1'b0),
    .ir  (1'b0),
    .q   (out_word)
  );

  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    ferr_d      = ferr_q;
    if (clr) begin
      cnt_d       = '0;
      out_valid_d = 1'b0;
      ferr_d      = 1'b0;
    end else begin
      if (restart) begin
        cnt_d  = CW'(1);
        ferr_d = 1'b1;
      end else if (acc) begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
      if (complete)  out_valid_d = 1'b1;
      else if (hs)   out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      ferr_q      <= ferr_d;
    end
  end

  assign bus.sin_ready   = sin_ready;
  assign bus.out_data    = out_word;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = (cnt_q != '0);
  assign bus.framing_err = ferr_q;
endmodule

// File: tb/tb_serial_deserializer.sv
// Drives an MSB-first and an LSB-first deserializer with one shared bit stream
// and compares both against a bit-queue reference model.
module tb_serial_deserializer;
  import gpu_pkg::*;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  serial_deserializer_if #(.DATA_WIDTH(W)) bm ();
  serial_deserializer_if #(.DATA_WIDTH(W)) bl ();

  serial_deserializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk), .rst_n (rst_n), .clr (clr), .bus (bm.slave));
  serial_deserializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk), .rst_n (rst_n), .clr (clr), .bus (bl.slave));

  int checks = 0;
  int errors = 0;

  // Reference model: bits of the word in progress, in arrival order.
  bit           q[$];
  bit           mov, mferr;
  logic [W-1:0] mdm, mdl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return !(q.size() == W - 1 && mov);
  endfunction

  function automatic logic [W-1:0] pack(input bit msb);
    logic [W-1:0] w = '0;
    foreach (q[i]) begin
      if (msb) w[W-1-i] = q[i];
      else     w[i]     = q[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    mov = 1'b0; mferr = 1'b0; mdm = '0; mdl = '0;
  endtask

  task automatic check_outs();
    chk("ovalid_m", bm.out_valid, mov);
    chk("ovalid_l", bl.out_valid, mov);
    chk("odata_m", bm.out_data, mdm);
    chk("odata_l", bl.out_data, mdl);
    chk("busy_m", bm.busy, q.size() != 0);
    chk("busy_l", bl.busy, q.size() != 0);
    chk("ferr_m", bm.framing_err, mferr);
    chk("ferr_l", bl.framing_err, mferr);
    chk("ready_m", bm.sin_ready, m_ready());
    chk("ready_l", bl.sin_ready, m_ready());
  endtask

  task automatic drive(input bit b, input bit v, input bit st, input bit ordy);
    bm.sin = b; bm.sin_valid = v; bm.sin_start = st; bm.out_ready = ordy;
    bl.sin = b; bl.sin_valid = v; bl.sin_start = st; bl.out_ready = ordy;
  endtask

  task automatic step(input bit b, input bit v, input bit st, input bit ordy,
                      input bit c, output bit accepted);
    bit cmp, hs;
    drive(b, v, st, ordy);
    clr = c;
    @(negedge clk);
    chk("ready_pre_m", bm.sin_ready, m_ready());
    chk("ready_pre_l", bl.sin_ready, m_ready());
    accepted = v && m_ready() && !c;
    cmp = 1'b0;
    hs  = mov && ordy;
    if (c) model_reset();
    else begin
      if (v && m_ready()) begin
        if (st && q.size() != 0) begin
          q.delete(); q.push_back(b); mferr = 1'b1;
        end else begin
          q.push_back(b);
          if (q.size() == W) begin
            cmp = 1'b1; mdm = pack(1'b1); mdl = pack(1'b0); q.delete();
          end
        end
      end
      if (cmp)     mov = 1'b1;
      else if (hs) mov = 1'b0;
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
    check_outs();
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit msb, input bit ordy,
                           input bit start_first);
    bit a, b;
    int tries;
    for (int i = 0; i < W; i++) begin
      b = msb ? w[W-1-i] : w[i];
      tries = 0;
      do begin
        step(b, 1'b1, start_first && i == 0, ordy, 1'b0, a);
        tries++;
      end while (!a && tries < 40);
      if (!a) chk("send_timeout", 32'(a), 32'd1);
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, ordy, 1'b0, a);
  endtask

  task automatic async_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ovalid", bm.out_valid, 1'b0);
    chk("rst_odata", bm.out_data, '0);
    chk("rst_busy", bl.busy, 1'b0);
    chk("rst_ferr", bl.framing_err, 1'b0);
    chk("rst_ready", bm.sin_ready, 1'b1);
    model_reset();
    check_outs();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit a;
    logic [W-1:0] rw;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #2;
    check_outs();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: MSB-first word, consumer always ready: one-cycle valid pulse
    send_word(16'hA5C3, 1'b1, 1'b1, 1'b0);
    chk("t1_data", bm.out_data, 16'hA5C3);
    chk("t1_valid", bm.out_valid, 1'b1);
    idle(1, 1'b1);
    chk("t1_pulse", bm.out_valid, 1'b0);

    // 2: LSB-first word
    send_word(16'h00F1, 1'b0, 1'b1, 1'b0);
    chk("t2_data", bl.out_data, 16'h00F1);
    chk("t2_busy", bl.busy, 1'b0);
    idle(1, 1'b1);

    // 3: backpressure on the last bit
    send_word(16'h1234, 1'b1, 1'b0, 1'b0);
    rw = 16'hBEEF;
    for (int i = 0; i < W - 1; i++) step(rw[W-1-i], 1'b1, 1'b0, 1'b0, 1'b0, a);
    for (int i = 0; i < 3; i++) begin
      step(rw[0], 1'b1, 1'b0, 1'b0, 1'b0, a);
      chk("t3_stall", 32'(a), 32'd0);
      chk("t3_hold", bm.out_data, 16'h1234);
    end
    step(rw[0], 1'b1, 1'b0, 1'b1, 1'b0, a);
    chk("t3_no_acc_on_hs", 32'(a), 32'd0);
    step(rw[0], 1'b1, 1'b0, 1'b0, 1'b0, a);
    chk("t3_acc", 32'(a), 32'd1);
    chk("t3_data", bm.out_data, 16'hBEEF);
    chk("t3_valid", bm.out_valid, 1'b1);
    idle(1, 1'b1);

    // 4: start bit mid-word restarts framing and latches the error
    for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, i == 0, 1'b1, 1'b0, a);
    send_word(16'h5A5A, 1'b1, 1'b1, 1'b1);
    chk("t4_ferr", bm.framing_err, 1'b1);
    chk("t4_data", bm.out_data, 16'h5A5A);
    idle(2, 1'b1);
    chk("t4_sticky", bm.framing_err, 1'b1);

    // 5: clear with a buffered word and a partial word in flight
    send_word(16'($urandom), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, a);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, a);
    chk("t5_busy", bm.busy, 1'b0);
    chk("t5_valid", bm.out_valid, 1'b0);
    chk("t5_ferr", bm.framing_err, 1'b0);
    send_word(16'hC0DE, 1'b1, 1'b1, 1'b0);
    chk("t5_data", bm.out_data, 16'hC0DE);
    idle(1, 1'b1);

    // 6: async reset mid-word, then mid-handshake
    for (int i = 0; i < 7; i++) step(1'($urandom), 1'b1, 1'b0, 1'b1, 1'b0, a);
    async_reset();
    send_word(16'h3C3C, 1'b1, 1'b0, 1'b0);
    async_reset();
    send_word(16'h9F31, 1'b1, 1'b1, 1'b0);
    chk("t6_data", bm.out_data, 16'h9F31);
    idle(1, 1'b1);

    // Randomized traffic with occasional starts, stalls and clears
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom), ($urandom % 4) != 0, ($urandom % 20) == 0,
           1'($urandom), ($urandom % 80) == 0, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
